// File: rtl/tap_recorder.sv
// tap_recorder: records the cassette-output waveform into the tape cache RAM.
// Rising edges of tape_out are timed in microsecond ticks. Each accepted
// period becomes one bit: short = 1, long = 0. The bits are framed as
// start(0), 8 data bits LSB first, odd parity, stop(1). Every good byte is
// written to the next cache location.
module tap_recorder #(
    parameter int US_DIV        = 24,
    parameter int MIN_PERIOD_US = 200,
    parameter int BIT_THRESH_US = 520,
    parameter int MAX_PERIOD_US = 1000,
    parameter int ADDR_W        = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              tape_out,
    input  logic              motor,
    input  logic              arm,
    input  logic              clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] rec_len,
    output logic              parity_err,
    output logic              frame_err,
    output logic              full,
    output logic              active
);

    // The prescaler is kept at least 1 bit wide so that US_DIV=1 still elaborates.
    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
    // The period counter must be able to hold the saturation value MAX+1.
    localparam int CW = $clog2(MAX_PERIOD_US + 2);

    localparam logic [PW-1:0] PRE_TOP = PW'(US_DIV - 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAX_PERIOD_US + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(MIN_PERIOD_US);
    localparam logic [CW-1:0] CNT_THR = CW'(BIT_THRESH_US);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PERIOD_US);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and rising-edge detect
    // ------------------------------------------------------------------
    // Bit 0 and bit 1 form the two-flop synchronizer. Bit 2 holds the previous
    // synchronized value for edge detection.
    logic [2:0] sync_q;
    logic       active_q;
    logic       rise;

    // Synchronize tape_out into the clk_sys domain and register the enable.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync_q   <= 3'b000;
            active_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], tape_out};
            active_q <= arm & motor;
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

    // ------------------------------------------------------------------
    // Period measurement
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          cnt_sat;
    logic          edge_ok;
    logic          long_edge;
    logic          bit_vld;
    logic          bit_val;

    assign tick      = (presc_q == PRE_TOP);
    assign cnt_sat   = (cnt_q == CNT_SAT);
    // An edge that comes too soon after the last accepted edge is a glitch.
    // Such an edge is ignored completely.
    assign edge_ok   = active_q & rise & (cnt_q >= CNT_MIN);
    assign long_edge = edge_ok & (cnt_q > CNT_MAX);
    assign bit_vld   = edge_ok & ~long_edge;
    assign bit_val   = (cnt_q <= CNT_THR);

    // Count microseconds since the last accepted edge, saturating as a timeout.
    always_ff @(posedge clk_sys) begin
        if (!reset_n || !active_q) begin
            presc_q <= '0;
            cnt_q   <= CNT_SAT;
        end else if (edge_ok) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick && !cnt_sat) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder and cache writer
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] rec_len_q, rec_len_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              full_w;

    // The last cache location is left unused, so rec_len never wraps to 0.
    assign full_w = &rec_len_q;

    // Register the frame state, recording position, and write port.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            rec_len_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rec_len_q  <= rec_len_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Compute the next frame state and the write request from each decoded bit.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rec_len_d  = rec_len_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        mem_wr_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        if (!active_q) begin
            // A relay drop or disarm discards any partial frame.
            state_d = S_IDLE;
        end else if (long_edge || (cnt_sat && state_q != S_IDLE)) begin
            // A dropout inside a frame aborts it silently.
            state_d = S_IDLE;
        end else if (bit_vld) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bit_val) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end
                end
                S_DATA: begin
                    shift_d  = {bit_val, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    // With odd parity, the data ones plus the parity bit must be odd.
                    if (^{shift_q, bit_val} == 1'b0) begin
                        perr_d = 1'b1;
                    end
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (bit_val) begin
                        if (!full_w) begin
                            mem_wr_d   = 1'b1;
                            mem_addr_d = rec_len_q;
                            mem_data_d = shift_q;
                            rec_len_d  = rec_len_q + 1'b1;
                        end
                    end else begin
                        // A bad stop bit discards the byte and is not a start bit.
                        ferr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Clear overrides everything, including a write in the same cycle.
        if (clear) begin
            state_d    = S_IDLE;
            rec_len_d  = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            mem_wr_d   = 1'b0;
            mem_addr_d = mem_addr_q;
            mem_data_d = mem_data_q;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_wr     = mem_wr_q;
    assign rec_len    = rec_len_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign full       = full_w;
    assign active     = active_q;

endmodule

// File: tb/tb_tap_recorder.sv
// tb_tap_recorder: drives tape waveforms with randomized frame content.
// A frame-level model predicts the writes and flags. The expected writes go
// into a queue, and a monitor pops that queue on every mem_wr. The timing
// parameters are scaled down so the run stays short.
`timescale 1ns/1ps
module tb_tap_recorder;

    localparam int US_DIV = 2;
    localparam int MINP   = 14;
    localparam int THR    = 40;
    localparam int MAXP   = 80;
    localparam int AW     = 4;
    localparam int P1     = 32;   // bit 1 period (us)
    localparam int P0     = 48;   // bit 0 period (us)
    localparam int GAP    = 150;  // dropout longer than MAXP
    localparam int LAST   = (1 << AW) - 1;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          tape_out = 1'b0;
    logic          motor = 1'b0;
    logic          arm = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_wr;
    logic [AW-1:0] rec_len;
    logic          parity_err, frame_err, full, active;

    tap_recorder #(
        .US_DIV(US_DIV), .MIN_PERIOD_US(MINP), .BIT_THRESH_US(THR),
        .MAX_PERIOD_US(MAXP), .ADDR_W(AW)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .tape_out(tape_out),
        .motor(motor), .arm(arm), .clear(clear),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
        .rec_len(rec_len), .parity_err(parity_err), .frame_err(frame_err),
        .full(full), .active(active)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  m_len = 0;
    bit  m_perr = 0;
    bit  m_ferr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each write must match the oldest predicted write.
    always @(negedge clk_sys) begin
        if (reset_n && mem_wr) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %02h, expected no write",
                         mem_addr, mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(mem_data), 32'(mon_e.data));
                check("wr_len", 32'(rec_len), 32'(mon_e.addr) + 1);
            end
        end
    end

    task automatic wait_us(input int n);
        repeat (n * US_DIV) @(posedge clk_sys);
        #1;
    endtask

    // One period, measured from rising edge to rising edge. An optional short
    // low pulse near the start adds a rising edge that is too early to count.
    task automatic send_period(input int p, input bit glitch);
        tape_out = 1'b1;
        if (glitch) begin
            wait_us(4); tape_out = 1'b0;
            wait_us(4); tape_out = 1'b1;
            wait_us(p / 2 - 8);
        end else begin
            wait_us(p / 2);
        end
        tape_out = 1'b0;
        wait_us(p - p / 2);
    endtask

    task automatic leader(input int n);
        repeat (n) send_period(P1, 1'b0);
    endtask

    task automatic do_clear();
        @(posedge clk_sys); #1 clear = 1'b1;
        @(posedge clk_sys); #1 clear = 1'b0;
        m_len = 0; m_perr = 0; m_ferr = 0;
    endtask

    // Frame-level reference. Predict the result first, then drive the waveform.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input int abort_after, input bit abort_motor);
        logic par;
        if (abort_after < 0) begin
            if (bad_par) m_perr = 1;
            if (bad_stop) m_ferr = 1;
            else if (m_len != LAST) begin
                exp_q.push_back('{addr: AW'(m_len), data: b});
                m_len++;
            end
        end
        par = (~^b) ^ bad_par;
        leader(2);
        send_period(P0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_period(b[i] ? P1 : P0, glitch_bit == i);
            if (i == abort_after) begin
                if (abort_motor) begin
                    motor = 1'b0;
                    wait_us(20);
                    check("active_off", 32'(active), 0);
                    motor = 1'b1;
                    wait_us(5);
                end else begin
                    wait_us(GAP);
                end
                leader(2);
                return;
            end
        end
        send_period(par ? P1 : P0, 1'b0);
        send_period(bad_stop ? P0 : P1, 1'b0);
        leader(1);
    endtask

    task automatic chk_state(input string tag);
        wait_us(4);
        check({tag, "_len"},  32'(rec_len), 32'(m_len));
        check({tag, "_perr"}, 32'(parity_err), 32'(m_perr));
        check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        check({tag, "_full"}, 32'(full), 32'(m_len == LAST));
        check({tag, "_pend"}, 32'(exp_q.size()), 0);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_addr"}, 32'(mem_addr), 0);
        check({tag, "_data"}, 32'(mem_data), 0);
        check({tag, "_wr"},   32'(mem_wr), 0);
        check({tag, "_len"},  32'(rec_len), 0);
        check({tag, "_perr"}, 32'(parity_err), 0);
        check({tag, "_ferr"}, 32'(frame_err), 0);
        check({tag, "_full"}, 32'(full), 0);
        check({tag, "_act"},  32'(active), 0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        repeat (5) @(posedge clk_sys);
        #1;
        chk_reset("reset");
        reset_n = 1'b1;
        arm = 1'b1; motor = 1'b1;
        wait_us(3);
        check("active_on", 32'(active), 1);

        // Good frame after a long leader.
        leader(10);
        send_frame(8'h5A, 0, 0, -1, -1, 0);
        chk_state("good");

        // Bad parity: the byte is still written.
        do_clear();
        send_frame(8'h5A, 1, 0, -1, -1, 0);
        chk_state("par");

        // A glitch inside data bit 3 is ignored.
        do_clear();
        send_frame(8'hA5, 0, 0, 3, -1, 0);
        chk_state("glitch");

        // A dropout after data bit 4 aborts the frame, then a good frame follows.
        do_clear();
        send_frame(8'h5A, 0, 0, -1, 4, 0);
        chk_state("gap");
        send_frame(8'h33, 0, 0, -1, -1, 0);
        chk_state("gap2");

        // A bad stop bit, then recovery, clear, and a relay drop mid-frame.
        do_clear();
        send_frame(8'h77, 0, 1, -1, -1, 0);
        chk_state("stop");
        send_frame(8'h11, 0, 0, -1, -1, 0);
        chk_state("stop2");
        do_clear();
        chk_state("clr");
        send_frame(8'h22, 0, 0, -1, 2, 1);
        chk_state("motor");

        // Fill the cache: 15 writes land, and the 16th byte is dropped.
        do_clear();
        for (int v = 0; v < 16; v++) begin
            send_frame(8'(v), 0, 0, -1, -1, 0);
            chk_state("fill");
        end

        // Randomized frames with random faults.
        do_clear();
        for (int k = 0; k < 12; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 4) == 0) do_clear();
            send_frame(rb, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 11),
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1,
                       1'($urandom_range(0, 1)));
            chk_state("rand");
        end

        // Reset clears every output.
        @(posedge clk_sys); #1 reset_n = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk_reset("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
